// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous-write memory.
// Round-robin with bounded burst locking; read data is registered back one cycle after the grant.
module mem_port_arbiter #(
    parameter int ASIZE     = 8,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             we0,
    input  logic [ASIZE-1:0] addr0,
    input  logic [DSIZE-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [DSIZE-1:0] rdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [ASIZE-1:0] addr1,
    input  logic [DSIZE-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [DSIZE-1:0] rdata1,
    output logic             mem_we,
    output logic [ASIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_in,
    input  logic [DSIZE-1:0] mem_out
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [DSIZE-1:0] rdata0_q, rdata0_d;
    logic [DSIZE-1:0] rdata1_q, rdata1_d;
    logic             at_limit;

    // Grant decision: an owner keeps the port until its burst limit is hit while the other side waits.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        at_limit = (cnt_q == CNT_MAX);
        if (!rst) begin
            if (owner_q == OWN_R0 && req0 && !(at_limit && req1)) begin
                gnt0 = 1'b1;
            end else if (owner_q == OWN_R1 && req1 && !(at_limit && req0)) begin
                gnt1 = 1'b1;
            end else if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (last_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_addr = gnt1 ? addr1 : addr0;
        mem_in   = gnt1 ? wdata1 : wdata0;
        mem_we   = (gnt0 & we0) | (gnt1 & we1);
    end

    always_comb begin
        owner_d   = OWN_NONE;
        cnt_d     = '0;
        last_d    = last_q;
        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
        rdata0_d  = rvalid0_d ? mem_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_out : rdata1_q;
        if (gnt0 || gnt1) begin
            owner_d = gnt0 ? OWN_R0 : OWN_R1;
            last_d  = gnt1;
            if (owner_q == owner_d) begin
                cnt_d = at_limit ? CNT_MAX : cnt_q + CW'(1);
            end
        end
    end

    // Grant-cycle to response-cycle boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance share stimulus,
// each with its own memory model; read responses are checked through queues by a monitor.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

    logic       a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_we;
    logic [7:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_in, a_mem_out;
    logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we;
    logic [7:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_in, b_mem_out;

    mem_port_arbiter #(.ASIZE(8), .DSIZE(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_in(a_mem_in), .mem_out(a_mem_out)
    );

    mem_port_arbiter #(.ASIZE(8), .DSIZE(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_in(b_mem_in), .mem_out(b_mem_out)
    );

    // Memory models: synchronous write, combinational read.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
            mem_a[8'h10] <= 8'hA5;
            mem_b[8'h10] <= 8'hA5;
            mem_a[8'h40] <= 8'h5A;
            mem_b[8'h40] <= 8'h5A;
        end else begin
            if (a_mem_we) mem_a[a_mem_addr] <= a_mem_in;
            if (b_mem_we) mem_b[b_mem_addr] <= b_mem_in;
        end
    end
    assign a_mem_out = mem_a[a_mem_addr];
    assign b_mem_out = mem_b[b_mem_addr];

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t q[4][$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Staged stimulus, applied just after the next rising edge by step().
    logic       s_rst = 1'b1;
    logic       s_req0 = 1'b0, s_we0 = 1'b0, s_req1 = 1'b0, s_we1 = 1'b0;
    logic [7:0] s_addr0 = '0, s_wd0 = '0, s_addr1 = '0, s_wd1 = '0;

    task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        s_req0 = r; s_we0 = w; s_addr0 = a; s_wd0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        s_req1 = r; s_we1 = w; s_addr1 = a; s_wd1 = d;
    endtask

    task automatic chk_dut(input string n, input logic [1:0] g, input logic we,
                           input logic [7:0] addr, input logic [1:0] eg);
        logic       exp_we;
        logic [7:0] exp_addr;
        checks++;
        if (g !== eg) begin
            failures++;
            $display("FAIL %s_gnt cyc=%0d: got %b expected %b", n, cyc, g, eg);
        end
        exp_we = (eg[0] & s_we0) | (eg[1] & s_we1);
        checks++;
        if (we !== exp_we) begin
            failures++;
            $display("FAIL %s_mem_we cyc=%0d: got %b expected %b", n, cyc, we, exp_we);
        end
        if (eg != 2'b00) begin
            exp_addr = eg[1] ? s_addr1 : s_addr0;
            checks++;
            if (addr !== exp_addr) begin
                failures++;
                $display("FAIL %s_mem_addr cyc=%0d: got %h expected %h", n, cyc, addr, exp_addr);
            end
        end
    endtask

    // ga/gb: expected {gnt1,gnt0} for the MAX_BURST=4 and MAX_BURST=1 instances.
    // e0/e1: hand-computed read data at R0's and R1's addresses for this cycle.
    task automatic step(input logic [1:0] ga, input logic [1:0] gb,
                        input logic [7:0] e0, input logic [7:0] e1);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s_rst;
        req0 = s_req0; we0 = s_we0; addr0 = s_addr0; wdata0 = s_wd0;
        req1 = s_req1; we1 = s_we1; addr1 = s_addr1; wdata1 = s_wd1;
        @(negedge clk);
        chk_dut("A", {a_gnt1, a_gnt0}, a_mem_we, a_mem_addr, ga);
        chk_dut("B", {b_gnt1, b_gnt0}, b_mem_we, b_mem_addr, gb);
        e.due = cyc + 1;
        if (ga[0] && !s_we0) begin e.data = e0; q[0].push_back(e); end
        if (ga[1] && !s_we1) begin e.data = e1; q[1].push_back(e); end
        if (gb[0] && !s_we0) begin e.data = e0; q[2].push_back(e); end
        if (gb[1] && !s_we1) begin e.data = e1; q[3].push_back(e); end
    endtask

    // Monitor: pops the read scoreboards whenever a response is due or presented.
    always @(negedge clk) begin
        logic [3:0] rvv;
        logic [7:0] rdv [4];
        exp_t       e;
        rvv    = {b_rvalid1, b_rvalid0, a_rvalid1, a_rvalid0};
        rdv[0] = a_rdata0;
        rdv[1] = a_rdata1;
        rdv[2] = b_rdata0;
        rdv[3] = b_rdata1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (rvv[p] === 1'b1) begin
                if (q[p].size() == 0 || q[p][0].due != cyc) begin
                    failures++;
                    $display("FAIL rvalid_port%0d cyc=%0d: got 1 expected 0", p, cyc);
                end else begin
                    e = q[p].pop_front();
                    checks++;
                    if (rdv[p] !== e.data) begin
                        failures++;
                        $display("FAIL rdata_port%0d cyc=%0d: got %h expected %h", p, cyc, rdv[p], e.data);
                    end
                end
            end else if (q[p].size() > 0 && q[p][0].due <= cyc) begin
                failures++;
                $display("FAIL rvalid_port%0d cyc=%0d: got %b expected 1", p, cyc, rvv[p]);
                void'(q[p].pop_front());
            end
        end
        checks++;
        if ((a_gnt0 & a_gnt1) === 1'b1 || (b_gnt0 & b_gnt1) === 1'b1) begin
            failures++;
            $display("FAIL gnt_mutex cyc=%0d: got A=%b%b B=%b%b expected one-hot or zero",
                     cyc, a_gnt1, a_gnt0, b_gnt1, b_gnt0);
        end
    end

    // Requester contract: a waiting request keeps its command stable.
    assert property (@(posedge clk) disable iff (rst)
        (req0 && !a_gnt0 && !b_gnt0) |=> (!req0 || $stable({we0, addr0, wdata0})))
        else begin failures++; $display("FAIL stable_req0 cyc=%0d", cyc); end
    assert property (@(posedge clk) disable iff (rst)
        (req1 && !a_gnt1 && !b_gnt1) |=> (!req1 || $stable({we1, addr1, wdata1})))
        else begin failures++; $display("FAIL stable_req1 cyc=%0d", cyc); end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        set0(0, 0, 8'h00, 8'h00);
        set1(0, 0, 8'h00, 8'h00);
        s_rst = 1'b1;
        step(2'b00, 2'b00, 8'h00, 8'h00);
        s_rst = 1'b0;
    endtask

    initial begin
        logic [9:0] pat_a;
        logic [9:0] pat_b;
        logic [1:0] ga, gb;
        pat_a = 10'b0011110000;
        pat_b = 10'b1010101010;

        // Reset, including a write request that must be ignored.
        s_rst = 1'b1;
        step(2'b00, 2'b00, 8'h00, 8'h00);
        mem_init = 1'b0;
        set0(1, 1, 8'hFF, 8'hEE);
        step(2'b00, 2'b00, 8'h00, 8'h00);
        s_rst = 1'b0;

        // Single read by R0.
        set0(1, 0, 8'h10, 8'h00);
        step(2'b01, 2'b01, 8'hA5, 8'h00);
        set0(0, 0, 8'h00, 8'h00);
        step(2'b00, 2'b00, 8'h00, 8'h00);

        // Contention: 4:4 bursts on A, strict alternation on B.
        do_reset();
        set0(1, 0, 8'h10, 8'h00);
        set1(1, 0, 8'h40, 8'h00);
        for (int i = 0; i < 10; i++) begin
            ga = pat_a[i] ? 2'b10 : 2'b01;
            gb = pat_b[i] ? 2'b10 : 2'b01;
            step(ga, gb, 8'hA5, 8'h5A);
        end
        set0(0, 0, 8'h00, 8'h00);
        set1(0, 0, 8'h00, 8'h00);
        step(2'b00, 2'b00, 8'h00, 8'h00);

        // R1 write stream saturating the burst counter, then R0 preempts.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set1(1, 1, 8'(i), 8'(8'h30 + i));
            step(2'b10, 2'b10, 8'h00, 8'h00);
        end
        set0(1, 0, 8'h05, 8'h00);
        set1(1, 1, 8'h0A, 8'h3A);
        step(2'b01, 2'b01, 8'h35, 8'h00);
        set0(0, 0, 8'h00, 8'h00);
        step(2'b10, 2'b10, 8'h00, 8'h00);
        set1(1, 0, 8'h0A, 8'h00);
        step(2'b10, 2'b10, 8'h00, 8'h3A);
        set1(0, 0, 8'h00, 8'h00);
        step(2'b00, 2'b00, 8'h00, 8'h00);

        // Write by R0 then read of the same address by R1 on the next cycle.
        do_reset();
        set0(1, 1, 8'h20, 8'h77);
        set1(1, 0, 8'h20, 8'h00);
        step(2'b01, 2'b01, 8'h00, 8'h00);
        set0(0, 0, 8'h00, 8'h00);
        step(2'b10, 2'b10, 8'h00, 8'h77);
        set1(0, 0, 8'h00, 8'h00);
        step(2'b00, 2'b00, 8'h00, 8'h00);

        // Reset in the middle of an R0 read burst.
        do_reset();
        set0(1, 0, 8'h10, 8'h00);
        step(2'b01, 2'b01, 8'hA5, 8'h00);
        step(2'b01, 2'b01, 8'hA5, 8'h00);
        s_rst = 1'b1;
        step(2'b00, 2'b00, 8'h00, 8'h00);
        s_rst = 1'b0;
        set0(0, 0, 8'h00, 8'h00);
        set1(1, 0, 8'h40, 8'h00);
        step(2'b10, 2'b10, 8'h00, 8'h5A);
        set1(0, 0, 8'h00, 8'h00);
        step(2'b00, 2'b00, 8'h00, 8'h00);
        step(2'b00, 2'b00, 8'h00, 8'h00);

        for (int p = 0; p < 4; p++) begin
            checks++;
            if (q[p].size() != 0) begin
                failures++;
                $display("FAIL drain_port%0d: got %0d pending expected 0", p, q[p].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
